// File: rtl/tff_updown_counter.sv
// tff_updown_counter: prescaled up/down counter built from a bank of toggle flip-flops.
// Define TFF_CNT_SATURATE_EN to saturate instead of wrapping at the count limits.
module tff_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int PS_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] q_next;
    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  ps_next;
    logic             ps_last;
    logic             wrap_next;

    assign q_bar   = ~q;
    assign tc      = up_dn ? &q : ~|q;
    assign ps_last = ps == PS_W'(PRESCALE - 1);

    // Toggle enables form a ripple carry (up) or borrow (down) chain.
    always_comb begin
        t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++)
            t[i] = t[i-1] & (up_dn ? q[i-1] : ~q[i-1]);
    end

`ifdef TFF_CNT_SATURATE_EN
    assign q_step = tc ? q : q ^ t;
`else
    assign q_step = q ^ t;
`endif

    always_comb begin
        q_next    = q;
        ps_next   = ps;
        wrap_next = 1'b0;
        if (op == 2'b01 || op == 2'b10) begin
            q_next  = op[1] ? load_val : '0;
            ps_next = '0;
        end else if (op == 2'b11) begin
            q_next    = ps_last ? q_step : q;
            ps_next   = ps_last ? '0 : ps + 1'b1;
            wrap_next = ps_last & tc;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q    <= '0;
            ps   <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            ps   <= ps_next;
            wrap <= wrap_next;
        end
    end
endmodule

// File: tb/tb_tff_updown_counter.sv
// tb_tff_updown_counter: directed checks of the TFF up/down counter at PRESCALE 1 and 3.
module tb_tff_updown_counter;
    logic       clk = 1'b0;
    logic       reset, en, up_dn;
    logic [1:0] op;
    logic [7:0] load_val;
    logic [7:0] q, q_bar, q3, q3_bar;
    logic       tc, wrap, tc3, wrap3;
    int         vectors = 0;
    int         miscompares = 0;

    tff_updown_counter #(.WIDTH(8), .PRESCALE(1), .PS_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .up_dn(up_dn), .load_val(load_val),
        .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap)
    );

    tff_updown_counter #(.WIDTH(8), .PRESCALE(3), .PS_W(8)) dut3 (
        .clk(clk), .reset(reset), .en(en), .op(op), .up_dn(up_dn), .load_val(load_val),
        .q(q3), .q_bar(q3_bar), .tc(tc3), .wrap(wrap3)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b1; op = 2'b11; up_dn = 1'b1; load_val = 8'h00;
        cyc(2);
        chk("rst_q", q, 8'h00);
        chk("rst_qbar", q_bar, 8'hFF);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_tc_up", tc, 1'b0);
        up_dn = 1'b0; #1;
        chk("rst_tc_dn", tc, 1'b1);
        // count up through the wrap
        reset = 1'b1; up_dn = 1'b1; op = 2'b10; load_val = 8'hFD;
        cyc(1); chk("load_fd", q, 8'hFD);
        op = 2'b11;
        cyc(1); chk("up_fe", q, 8'hFE); chk("up_fe_tc", tc, 1'b0); chk("up_fe_wrap", wrap, 1'b0);
        cyc(1); chk("up_ff", q, 8'hFF); chk("up_ff_tc", tc, 1'b1); chk("up_ff_wrap", wrap, 1'b0);
`ifdef TFF_CNT_SATURATE_EN
        cyc(1); chk("up_00", q, 8'hFF); chk("up_00_wrap", wrap, 1'b1);
        op = 2'b00;
        cyc(1); chk("up_01", q, 8'hFF); chk("up_01_wrap", wrap, 1'b0);
`else
        cyc(1); chk("up_00", q, 8'h00); chk("up_00_wrap", wrap, 1'b1); chk("up_00_tc", tc, 1'b0);
        cyc(1); chk("up_01", q, 8'h01); chk("up_01_wrap", wrap, 1'b0);
`endif
        // prescale 3 with a frozen window
        op = 2'b01;
        cyc(1); chk("clr_q3", q3, 8'h00); chk("clr_q", q, 8'h00);
        op = 2'b11;
        cyc(4); chk("ps_4", q3, 8'h01); chk("ps1_4", q, 8'h04);
        en = 1'b0;
        cyc(4); chk("frz_q3", q3, 8'h01); chk("frz_q", q, 8'h04);
        en = 1'b1;
        cyc(4); chk("ps_8", q3, 8'h02);
        cyc(1); chk("ps_9", q3, 8'h03); chk("ps_9_wrap", wrap3, 1'b0);
        // wrap persists while disabled
        op = 2'b10; load_val = 8'hFF;
        cyc(1);
        op = 2'b11;
        cyc(1); chk("enw_wrap", wrap, 1'b1);
        en = 1'b0;
        cyc(2); chk("enw_hold", wrap, 1'b1);
        en = 1'b1; op = 2'b00;
        cyc(1); chk("hold_clr_wrap", wrap, 1'b0);
        // count down through zero
        op = 2'b10; load_val = 8'h01; up_dn = 1'b0;
        cyc(1); chk("load_01", q, 8'h01);
        op = 2'b11;
        cyc(1); chk("dn_00", q, 8'h00); chk("dn_00_wrap", wrap, 1'b0); chk("dn_00_tc", tc, 1'b1);
`ifdef TFF_CNT_SATURATE_EN
        cyc(1); chk("dn_ff", q, 8'h00);
`else
        cyc(1); chk("dn_ff", q, 8'hFF); chk("dn_ff_qbar", q_bar, 8'h00);
`endif
        chk("dn_ff_wrap", wrap, 1'b1);
        op = 2'b00;
        cyc(1); chk("dn_hold_wrap", wrap, 1'b0);
        // load mid-count, then reset beats load
        op = 2'b10; load_val = 8'h00; up_dn = 1'b1;
        cyc(1);
        op = 2'b11;
        cyc(2); chk("mid_2", q, 8'h02);
        op = 2'b10; load_val = 8'h5A;
        cyc(1); chk("mid_5a", q, 8'h5A); chk("mid_5a_q3", q3, 8'h5A);
        op = 2'b11;
        cyc(2); chk("mid_ps0_a", q3, 8'h5A);
        cyc(1); chk("mid_ps0_b", q3, 8'h5B);
        reset = 1'b0; op = 2'b10;
        cyc(1); chk("rst_wins", q, 8'h00); chk("rst_wins_q3", q3, 8'h00);
        // direction flip
        reset = 1'b1; op = 2'b11; up_dn = 1'b1;
        cyc(4); chk("flip_4", q, 8'h04);
        up_dn = 1'b0;
        cyc(1); chk("flip_3", q, 8'h03); chk("flip_3_wrap", wrap, 1'b0);
        cyc(1); chk("flip_2", q, 8'h02); chk("flip_2_wrap", wrap, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
